cut_bist_controller: RTL and testbench

//  Built-in self-test sequencer for a 16-in/16-out combinational circuit-under-test (CUT) netlist.
//  - Applies NUM_PATTERNS pseudo-random input vectors from an LFSR to the CUT.
//  - After a settle period per vector, compacts CUT outputs into a MISR signature.
//  - On completion, compares the signature against a golden value.
//  - Sits between the fault-simulation harness (start/abort/result) and the CUT's primary I/O.

---
 rtl/bist_pkg.sv | 21 ++
 rtl/bist_shift_reg.sv | 40 ++++
 rtl/cut_bist_controller.sv | 140 ++++++++++++++
 tb/tb_cut_bist_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// ============================================================================
// bist_pkg -- shared state encoding and default LFSR/MISR constants for BIST.
// Rev 1.0
// ============================================================================
`default_nettype none

package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_e;

  localparam logic [15:0] C_DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] C_DEFAULT_SEED = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/bist_shift_reg.sv
// ============================================================================
// bist_shift_reg -- seedable shift register with XOR feedback and parallel XOR-in
// (LFSR when xor_i is tied low, MISR otherwise). Rev 1.0
// ============================================================================
`default_nettype none

module bist_shift_reg
  import bist_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(C_DEFAULT_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] xor_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;

  assign reg_d   = {reg_q[WIDTH-2:0], ^(reg_q & TAPS)} ^ xor_i;
  assign value_o = reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
    end else if (load_i) begin
      reg_q <= seed_i;
    end else if (advance_i) begin
      reg_q <= reg_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cut_bist_controller.sv
// ============================================================================
// cut_bist_controller -- LFSR-driven BIST sequencer with MISR compaction and
// golden-signature compare for a combinational CUT. Rev 1.0
// ============================================================================
`default_nettype none

module cut_bist_controller
  import bist_pkg::*;
#(
  parameter int              PI_W         = 16,
  parameter int              PO_W         = 16,
  parameter int              NUM_PATTERNS = 256,
  parameter int              SETTLE       = 1,
  parameter logic [PI_W-1:0] LFSR_TAPS    = PI_W'(C_DEFAULT_TAPS),
  parameter logic [PO_W-1:0] MISR_TAPS    = PO_W'(C_DEFAULT_TAPS),
  parameter logic [PI_W-1:0] LFSR_SEED    = PI_W'(C_DEFAULT_SEED),
  parameter logic [PO_W-1:0] MISR_SEED    = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [PO_W-1:0]                     golden_sig,
  output logic [PI_W-1:0]                     cut_pi,
  input  logic [PO_W-1:0]                     cut_po,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [PO_W-1:0]                     signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]   pattern_idx
);

  localparam int               IDX_W    = $clog2(NUM_PATTERNS + 1);
  localparam int               CNT_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [PI_W-1:0]  SEED_EFF = (LFSR_SEED == '0) ? PI_W'(1) : LFSR_SEED;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam bist_state_e      RUN_ST   = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PO_W-1:0]  golden_q;
  logic             load;
  logic             advance;
  logic             capture_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      golden_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (capture_last) begin
        golden_q <= golden_sig;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    load         = 1'b0;
    advance      = 1'b0;
    capture_last = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            load    = 1'b1;
            state_d = RUN_ST;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        ST_SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          advance = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            capture_last = 1'b1;
            state_d      = ST_DONE;
          end else begin
            state_d = RUN_ST;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  bist_shift_reg #(
    .WIDTH (PI_W),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .seed_i    (SEED_EFF),
    .advance_i (advance),
    .xor_i     ('0),
    .value_o   (cut_pi)
  );

  bist_shift_reg #(
    .WIDTH (PO_W),
    .TAPS  (MISR_TAPS)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .seed_i    (MISR_SEED),
    .advance_i (advance),
    .xor_i     (cut_po),
    .value_o   (signature)
  );

  // The signature is frozen in DONE, so comparing against the golden value
  // latched on the last capture edge gives the verdict; leaving DONE clears it.
  assign pass        = (state_q == ST_DONE) && (signature == golden_q);
  assign busy        = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign done        = (state_q == ST_DONE);
  assign pattern_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_cut_bist_controller.sv
// ============================================================================
// tb_cut_bist_controller -- four parameterisations of the BIST controller run
// against a cycle-count based reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_cut_bist_controller;

  localparam int NI = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cut_po;
  logic [15:0] golden;

  logic [15:0] pi_w   [NI];
  logic [15:0] sig_w  [NI];
  logic [15:0] idx_w  [NI];
  logic        busy_w [NI];
  logic        done_w [NI];
  logic        pass_w [NI];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int np_of(input int i);
    case (i)
      0:       return 2;
      1:       return 2;
      2:       return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int st_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic logic [15:0] ls_of(input int i);
    return (i == 3) ? 16'h0000 : 16'hACE1;
  endfunction

  function automatic logic [15:0] ms_of(input int i);
    return (i == 3) ? 16'h1234 : 16'h0000;
  endfunction

  function automatic logic [15:0] step(input logic [15:0] x, input logic [15:0] din);
    return {x[14:0], ^(x & 16'hB400)} ^ din;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int          NP  = np_of(gi);
    localparam int          ST  = st_of(gi);
    localparam logic [15:0] LS  = ls_of(gi);
    localparam logic [15:0] MS  = ms_of(gi);
    localparam logic [15:0] LSE = (LS == 16'h0000) ? 16'h0001 : LS;
    localparam int          IW  = $clog2(NP + 1);

    logic [15:0]   pi;
    logic [15:0]   sig;
    logic [IW-1:0] idx;
    logic          b;
    logic          d;
    logic          p;

    cut_bist_controller #(
      .PI_W         (16),
      .PO_W         (16),
      .NUM_PATTERNS (NP),
      .SETTLE       (ST),
      .LFSR_TAPS    (16'hB400),
      .MISR_TAPS    (16'hB400),
      .LFSR_SEED    (LS),
      .MISR_SEED    (MS)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .golden_sig  (golden),
      .cut_pi      (pi),
      .cut_po      (cut_po),
      .busy        (b),
      .done        (d),
      .pass        (p),
      .signature   (sig),
      .pattern_idx (idx)
    );

    assign pi_w[gi]   = pi;
    assign sig_w[gi]  = sig;
    assign idx_w[gi]  = 16'(idx);
    assign busy_w[gi] = b;
    assign done_w[gi] = d;
    assign pass_w[gi] = p;

    // Model: mode 0 idle, 1 running, 2 done; t counts edges since start,
    // a capture happens on every (ST+1)-th edge.
    int          m_mode    = 0;
    int          m_t       = 0;
    int          m_idx     = 0;
    logic [15:0] m_pi      = '0;
    logic [15:0] m_sig     = '0;
    logic        m_pass    = 1'b0;
    logic        m_pass_ok = 1'b1;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_mode    <= 0;
        m_t       <= 0;
        m_idx     <= 0;
        m_pi      <= '0;
        m_sig     <= '0;
        m_pass    <= 1'b0;
        m_pass_ok <= 1'b1;
      end else if (abort) begin
        m_mode    <= 0;
        m_pass    <= 1'b0;
        m_pass_ok <= 1'b1;
      end else if (start && m_mode != 1) begin
        m_mode    <= 1;
        m_t       <= 0;
        m_idx     <= 0;
        m_pi      <= LSE;
        m_sig     <= MS;
        m_pass    <= 1'b0;
        m_pass_ok <= 1'b0;
      end else if (m_mode == 1) begin
        m_t <= m_t + 1;
        if ((m_t + 1) % (ST + 1) == 0) begin
          m_pi  <= step(m_pi, 16'h0000);
          m_sig <= step(m_sig, cut_po);
          m_idx <= m_idx + 1;
          if (m_idx + 1 == NP) begin
            m_mode    <= 2;
            m_pass    <= (step(m_sig, cut_po) == golden);
            m_pass_ok <= 1'b1;
          end
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("i%0d.cut_pi", gi), 32'(pi), 32'(m_pi));
      chk($sformatf("i%0d.signature", gi), 32'(sig), 32'(m_sig));
      chk($sformatf("i%0d.pattern_idx", gi), 32'(idx), 32'(m_idx));
      chk($sformatf("i%0d.busy", gi), 32'(b), 32'(m_mode == 1));
      chk($sformatf("i%0d.done", gi), 32'(d), 32'(m_mode == 2));
      if (m_pass_ok) begin
        chk($sformatf("i%0d.pass", gi), 32'(p), 32'(m_pass));
      end
    end
  end

  task automatic chk_reset_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s.i%0d.cut_pi", tag, i), 32'(pi_w[i]), 32'h0);
      chk($sformatf("%s.i%0d.signature", tag, i), 32'(sig_w[i]), 32'h0);
      chk($sformatf("%s.i%0d.pattern_idx", tag, i), 32'(idx_w[i]), 32'h0);
      chk($sformatf("%s.i%0d.busy", tag, i), 32'(busy_w[i]), 32'h0);
      chk($sformatf("%s.i%0d.done", tag, i), 32'(done_w[i]), 32'h0);
      chk($sformatf("%s.i%0d.pass", tag, i), 32'(pass_w[i]), 32'h0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    cut_po = 16'h0000;
    golden = 16'h0000;
    repeat (3) @(negedge clk);
    chk_reset_all("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_all("idle_no_start");

    // Short runs: NP=2/SETTLE=1 and NP=2/SETTLE=0 with a constant CUT response.
    cut_po = 16'h0001;
    golden = 16'h0003;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("seq.e1.pi0", 32'(pi_w[0]), 32'hACE1);
    @(negedge clk);
    chk("seq.e2.pi0", 32'(pi_w[0]), 32'hACE1);
    chk("seq.e2.sig1", 32'(sig_w[1]), 32'h0001);
    @(negedge clk);
    chk("seq.e3.pi0", 32'(pi_w[0]), 32'h59C3);
    chk("seq.e3.sig1", 32'(sig_w[1]), 32'h0003);
    chk("seq.e3.done1", 32'(done_w[1]), 32'h1);
    chk("seq.e3.pass1", 32'(pass_w[1]), 32'h1);
    @(negedge clk);
    chk("seq.e4.done0", 32'(done_w[0]), 32'h0);
    @(negedge clk);
    chk("seq.e5.done0", 32'(done_w[0]), 32'h1);

    // Rerun from DONE with a wrong golden value.
    golden = 16'h0004;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun.done1_drops", 32'(done_w[1]), 32'h0);
    chk("rerun.busy1", 32'(busy_w[1]), 32'h1);
    repeat (2) @(negedge clk);
    chk("rerun.done1", 32'(done_w[1]), 32'h1);
    chk("rerun.pass1", 32'(pass_w[1]), 32'h0);
    chk("rerun.sig1", 32'(sig_w[1]), 32'h0003);

    // Abort during the third capture of the NP=8 instance.
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort.pre.idx2", 32'(idx_w[2]), 32'h2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort.idx2", 32'(idx_w[2]), 32'h2);
    chk("abort.busy2", 32'(busy_w[2]), 32'h0);
    chk("abort.done2", 32'(done_w[2]), 32'h0);
    chk("abort.pass2", 32'(pass_w[2]), 32'h0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort.busy2", 32'(busy_w[2]), 32'h0);
    chk("start_abort.idx2", 32'(idx_w[2]), 32'h2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart.pi2", 32'(pi_w[2]), 32'hACE1);
    chk("restart.idx2", 32'(idx_w[2]), 32'h0);
    chk("restart.busy2", 32'(busy_w[2]), 32'h1);
    chk("restart.pi3_seed_sub", 32'(pi_w[3]), 32'h0001);
    chk("restart.sig3_seed", 32'(sig_w[3]), 32'h1234);

    // Asynchronous reset in the middle of a SETTLE cycle.
    #2 rst_n = 1'b0;
    #1 chk_reset_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3000) begin
      @(negedge clk);
      start  = ($urandom_range(0, 5) == 0);
      abort  = ($urandom_range(0, 31) == 0);
      cut_po = 16'($urandom);
      golden = ($urandom_range(0, 1) == 0) ? 16'h0003 : 16'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
